// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin arbiter that drives the
// select pair of the 4:1 single-bit mux.
package mux_arb_pkg;

  localparam int NUM_REQ      = 4;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: searches upward from last+1
// (with wrap) over the unmasked request bits and reports the first hit.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  input  logic [NUM_REQ-1:0] mask,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [NUM_REQ-1:0] w_elig;
  logic [1:0]         w_cand;

  assign w_elig = req & ~mask;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid  = 1'b0;
    idx    = 2'd0;
    w_cand = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = last + k[1:0];
      if (w_elig[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning sel1/sel2 of the 4:1 mux. Optional grant
// timeout (preemption after HOLD_MAX cycles) is enabled by MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int NUM_REQ  = mux_arb_pkg::NUM_REQ,
  parameter int HOLD_MAX = mux_arb_pkg::HOLD_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               sel1,
  output logic               sel2,
  output logic               busy
);

  import mux_arb_pkg::*;

  if (NUM_REQ != 4 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_cfg
    $error("mux_rr_arbiter: NUM_REQ must be 4 and HOLD_MAX within 1..255");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [1:0]         r_last;
  logic [1:0]         w_last_nxt;
  logic [1:0]         r_sel;
  logic [1:0]         w_sel_nxt;
  logic               r_busy;
  logic               w_new;
  logic               w_own_req;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_mask;
  logic               w_valid;
  logic [1:0]         w_idx;

  // While in GRANT, r_last is the current owner's index.
  assign w_own_req = req[r_last];
  assign w_mask    = (r_state == GRANT && w_own_req) ? idx_to_onehot(r_last) : 4'b0000;

  rr_pick u_pick (
    .req   (req),
    .last  (r_last),
    .mask  (w_mask),
    .valid (w_valid),
    .idx   (w_idx)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] r_cnt;

  assign w_timeout = (r_cnt == HOLD_LAST);

  // Tenure counter: cleared on each new grant or idle, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_new || w_state_nxt == IDLE) begin
      r_cnt <= 8'd0;
    end else if (r_cnt != HOLD_LAST) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state logic; a new winner is taken in the same edge the owner leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_new       = 1'b0;
    case (r_state)
      IDLE: begin
        w_new = w_valid;
      end
      GRANT: begin
        if (!w_own_req) begin
          if (w_valid) begin
            w_new = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = {NUM_REQ{1'b0}};
          end
        end else begin
          w_new = w_timeout && w_valid;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = {NUM_REQ{1'b0}};
      end
    endcase
    if (w_new) begin
      w_state_nxt = GRANT;
      w_grant_nxt = idx_to_onehot(w_idx);
      w_last_nxt  = w_idx;
      w_sel_nxt   = w_idx;
    end else begin
      w_last_nxt  = r_last;
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= {NUM_REQ{1'b0}};
      r_last  <= 2'd3;
      r_sel   <= SEL_A;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= |w_grant_nxt;
    end
  end

  assign grant = r_grant;
  assign sel1  = r_sel[1];
  assign sel2  = r_sel[0];
  assign busy  = r_busy;

endmodule
